pc_ctrl: RTL and testbench

Program-counter and fetch-control stage for the 8-bit accumulator core. It sits directly downstream of the ALU: each cycle it takes the current opcode and ALU result, resolves beq/bne/jump through a branch-target lookup table, and registers the next PC that addresses instruction memory. It also owns the start/done run handshake for the whole program.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/pc_ctrl_if.sv | 48 ++++
 rtl/pc_ctrl_branch_lut.sv | 31 +++
 rtl/pc_ctrl.sv | 132 +++++++++++++
 tb/tb_pc_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator core: opcode constants, the
// fetch-control state type and the default PC/LUT geometry.
package cpu_pkg;

  localparam int PC_W_DEF   = 10;
  localparam int LUT_AW_DEF = 5;

  localparam logic [3:0] OP_BEQ  = 4'b1100;
  localparam logic [3:0] OP_BNE  = 4'b1101;
  localparam logic [3:0] OP_JMP  = 4'b1110;
  localparam logic [3:0] OP_DONE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_ctrl_if.sv
// Bus bundle between the core and the pc_ctrl fetch stage.
// Optional feature macro: FETCH_PERF_CNT_EN adds the retired/taken counters.
//
// Run handshake: start is a request level that is accepted on any rising edge
// where the stage is not running (IDLE or HALT); start seen while running is
// ignored. done is the completion flag: it rises the cycle after the done
// opcode retires and stays high until the next accepted start. stall is a
// per-cycle hold that only has meaning while running.
interface pc_ctrl_if #(
  parameter int PC_W   = cpu_pkg::PC_W_DEF,
  parameter int LUT_AW = cpu_pkg::LUT_AW_DEF
);
  import cpu_pkg::*;

  logic              start;
  logic              stall;
  logic [3:0]        opcode;
  logic [7:0]        alu_rslt;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_addr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   pc_o;
  logic              fetch_en;
  logic              done;
  logic              bad_tgt;
  pc_state_t         state_dbg;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]       retired;
  logic [15:0]       taken;
`endif

  modport master (
    output start, stall, opcode, alu_rslt, lut_we, lut_addr, lut_wdata,
`ifdef FETCH_PERF_CNT_EN
    input  retired, taken,
`endif
    input  pc_o, fetch_en, done, bad_tgt, state_dbg
  );

  modport slave (
    input  start, stall, opcode, alu_rslt, lut_we, lut_addr, lut_wdata,
`ifdef FETCH_PERF_CNT_EN
    output retired, taken,
`endif
    output pc_o, fetch_en, done, bad_tgt, state_dbg
  );

endinterface

// File: rtl/pc_ctrl_branch_lut.sv
// Branch-target lookup table: asynchronous read, synchronous write,
// every entry cleared by the asynchronous reset.
module branch_lut #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [LUT_AW-1:0] waddr_i,
  input  logic [PC_W-1:0]   wdata_i,
  input  logic [LUT_AW-1:0] raddr_i,
  output logic [PC_W-1:0]   rdata_o
);

  localparam int DEPTH = 1 << LUT_AW;

  logic [PC_W-1:0] mem_q [DEPTH];

  // Storage: cleared on reset, written on the edge when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter and fetch-control stage. Resolves beq/bne/jump through the
// branch-target LUT and owns the start/done run handshake.
// Optional feature macro: FETCH_PERF_CNT_EN (retired / taken counters).
module pc_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int LUT_AW = LUT_AW_DEF
) (
  input logic       clk,
  input logic       rst_n,
  pc_ctrl_if.slave  bus
);

  pc_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            bad_q, bad_d;

  logic            run_start;
  logic            retire;
  logic            br_req;
  logic            in_range;
  logic            lut_wr_en;
  logic [PC_W-1:0] lut_rdata;

  // A start is accepted only while not running; a run cycle retires unless stalled.
  assign run_start = (state_q != RUN) && bus.start;
  assign retire    = (state_q == RUN) && !bus.stall;

  // The ALU zeroes untaken branches, so a non-zero result means "taken".
  assign br_req   = ((bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE) ||
                     (bus.opcode == OP_JMP)) && (bus.alu_rslt != 8'd0);
  assign in_range = (bus.alu_rslt >> LUT_AW) == 8'd0;

  // Table writes are only honoured while the program is not running.
  assign lut_wr_en = bus.lut_we && (state_q != RUN);

  branch_lut #(
    .PC_W   (PC_W),
    .LUT_AW (LUT_AW)
  ) u_lut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (lut_wr_en),
    .waddr_i (bus.lut_addr),
    .wdata_i (bus.lut_wdata),
    .raddr_i (bus.alu_rslt[LUT_AW-1:0]),
    .rdata_o (lut_rdata)
  );

  // Next-state / next-PC selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bad_d   = bad_q;
    case (state_q)
      IDLE, HALT: begin
        if (run_start) begin
          state_d = RUN;
          pc_d    = '0;
          bad_d   = 1'b0;
        end
      end
      RUN: begin
        if (retire) begin
          if (bus.opcode == OP_DONE) begin
            state_d = HALT;
          end else if (br_req && in_range) begin
            pc_d = lut_rdata;
          end else begin
            pc_d = pc_q + 1'b1;
            if (br_req) bad_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC and sticky bad-target flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
    end
  end

  assign bus.pc_o      = pc_q;
  assign bus.fetch_en  = retire;
  assign bus.done      = (state_q == HALT);
  assign bus.bad_tgt   = bad_q;
  assign bus.state_dbg = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] retired_q, retired_d;
  logic [15:0] taken_q, taken_d;

  // Saturating performance counters, cleared when a run is started.
  always_comb begin
    retired_d = retired_q;
    taken_d   = taken_q;
    if (run_start) begin
      retired_d = '0;
      taken_d   = '0;
    end else if (retire) begin
      if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
      if ((bus.opcode != OP_DONE) && br_req && in_range && (taken_q != 16'hFFFF))
        taken_d = taken_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else begin
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  assign bus.retired = retired_q;
  assign bus.taken   = taken_q;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Testbench for pc_ctrl: directed scenarios followed by randomized traffic,
// all outputs compared against a behavioural model of the fetch stage.
module tb_pc_ctrl;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 5;
  localparam int PC_MOD = 1 << PC_W;
  localparam int LUT_N  = 1 << LUT_AW;

  logic clk;
  logic rst_n;

  pc_ctrl_if #(.PC_W(PC_W), .LUT_AW(LUT_AW)) bus ();

  pc_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Program status is tracked as "running" and "halted" flags, the PC as a
  // plain integer and the table as an integer array.
  bit m_run, m_halt, m_bad;
  int m_pc, m_ret, m_tkn;
  int m_lut [LUT_N];

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_halt = 0; m_bad = 0;
    m_pc = 0; m_ret = 0; m_tkn = 0;
    for (int i = 0; i < LUT_N; i++) m_lut[i] = 0;
  endtask

  task automatic model_edge(input bit st, input bit stl, input int op, input int alu,
                            input bit we, input int addr, input int wd);
    if (!m_run) begin
      if (we) m_lut[addr] = wd;
      if (st) begin
        m_run = 1; m_halt = 0; m_bad = 0;
        m_pc = 0; m_ret = 0; m_tkn = 0;
      end
    end else if (!stl) begin
      m_ret = sat_inc(m_ret);
      if (op == 15) begin
        m_run = 0; m_halt = 1;
      end else if (op >= 12 && alu != 0) begin
        if (alu < LUT_N) begin
          m_pc  = m_lut[alu];
          m_tkn = sat_inc(m_tkn);
        end else begin
          m_pc  = (m_pc + 1) % PC_MOD;
          m_bad = 1;
        end
      end else begin
        m_pc = (m_pc + 1) % PC_MOD;
      end
    end
  endtask

  task automatic check_regs(input string where);
    check({where, ".pc"},      32'(bus.pc_o),    32'(m_pc));
    check({where, ".done"},    32'(bus.done),    32'(m_halt));
    check({where, ".bad_tgt"}, 32'(bus.bad_tgt), 32'(m_bad));
`ifdef FETCH_PERF_CNT_EN
    check({where, ".retired"}, 32'(bus.retired), 32'(m_ret));
    check({where, ".taken"},   32'(bus.taken),   32'(m_tkn));
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: applies inputs, checks fetch_en, clocks once,
  // checks registered outputs and returns at the next falling edge.
  task automatic cycle(input bit st, input bit stl, input int op, input int alu,
                       input bit we = 0, input int addr = 0, input int wd = 0);
    bus.start     = st;
    bus.stall     = stl;
    bus.opcode    = 4'(op);
    bus.alu_rslt  = 8'(alu);
    bus.lut_we    = we;
    bus.lut_addr  = LUT_AW'(addr);
    bus.lut_wdata = PC_W'(wd);
    #1;
    check("fetch_en", 32'(bus.fetch_en), 32'(m_run && !stl));
    @(posedge clk);
    model_edge(st, stl, op, alu, we, addr, wd);
    #1;
    check_regs("cyc");
    @(negedge clk);
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("rst");
    check("rst.fetch_en", 32'(bus.fetch_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.stall     = 1'b0;
    bus.opcode    = 4'd0;
    bus.alu_rslt  = 8'd0;
    bus.lut_we    = 1'b0;
    bus.lut_addr  = '0;
    bus.lut_wdata = '0;
    model_reset();
    @(negedge clk);
    check_regs("por");
    rst_n = 1'b1;

    // idle with no start: nothing moves
    cycle(0, 0, 0, 0);
    cycle(0, 1, 12, 3);
    // program the table while idle
    cycle(0, 0, 0, 0, 1, 3, 200);
    cycle(0, 0, 0, 0, 1, 4, 7);
    cycle(0, 0, 0, 0, 1, 5, 1023);
    // start together with a table write
    cycle(1, 0, 0, 0, 1, 6, 50);
    // sequential fetch 0..4, with a three-cycle stall at PC 4
    cycle(0, 0, 1, 0);
    cycle(0, 0, 2, 0);
    cycle(1, 0, 3, 9);          // start ignored while running
    cycle(0, 0, 4, 0);
    cycle(0, 1, 12, 3);
    cycle(0, 1, 12, 3);
    cycle(0, 1, 15, 0);
    cycle(0, 0, 5, 0);          // PC 4 -> 5
    cycle(0, 0, 13, 4);         // bne taken via LUT[4] -> 7
    cycle(0, 0, 13, 0);         // bne untaken at 7 -> 8
    cycle(0, 0, 14, 40);        // out-of-range jump -> 9, bad_tgt
    cycle(0, 0, 15, 0);         // done at PC 9
    cycle(0, 1, 0, 0);          // halted, stall ignored
    cycle(0, 0, 0, 0, 1, 2, 1023);  // table write in HALT
    cycle(1, 0, 0, 0);          // restart
    cycle(0, 0, 12, 3);         // beq -> 200
    cycle(0, 0, 14, 2);         // jump -> 1023 (entry written in HALT)
    cycle(0, 0, 0, 0);          // wrap to 0
    cycle(0, 0, 14, 6, 1, 6, 99);   // write in RUN dropped; jump -> 50
    cycle(0, 0, 1, 255);        // non-branch with non-zero result
    mid_reset();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 12, 3);         // table cleared by reset -> 0
    cycle(0, 0, 12, 0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int op, alu, sel;
      bit st, stl, we;
      if (n == 700) mid_reset();
      op  = $urandom_range(0, 15);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       alu = 0;
        1:       alu = $urandom_range(1, LUT_N - 1);
        2:       alu = $urandom_range(LUT_N, 255);
        default: alu = $urandom_range(0, 40);
      endcase
      st  = ($urandom_range(0, 5) == 0);
      stl = ($urandom_range(0, 4) == 0);
      we  = ($urandom_range(0, 2) == 0);
      cycle(st, stl, op, alu, we, $urandom_range(0, LUT_N - 1), $urandom_range(0, PC_MOD - 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
